// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and default widths for the clock divider
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ch_state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one divider channel: FSM, half-period counter, shadow divide register
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   en           run enable (level)
//   load         one-cycle request to capture div_val into the pending register
//   div_val      half-period in clk cycles (0 = stopped)
//   clk_out      registered 50% duty divided clock
//   tick         one-cycle pulse in the cycle clk_out changes
//   load_ack     one-cycle pulse in the cycle a captured value becomes active
//   busy         channel is not IDLE
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_val,
    output logic             clk_out,
    output logic             tick,
    output logic             load_ack,
    output logic             busy
);

    ch_state_t        state;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] cnt;
    logic             pend;

    logic             hit;
    logic             boundary;
    logic             apply;
    logic [CNT_W-1:0] next_active;

    always_comb begin
        // active is never 0 outside IDLE, so the wrap of active-1 is unreachable
        hit         = (state != IDLE) && (cnt == active - CNT_W'(1));
        // the period boundary is the high-to-low toggle
        boundary    = hit && clk_out;
        apply       = pend && ((state == IDLE) || boundary);
        next_active = apply ? pending : active;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            active   <= '0;
            pending  <= '0;
            pend     <= 1'b0;
            cnt      <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            tick     <= 1'b0;
            load_ack <= apply;
            if (apply) begin
                active <= pending;
            end
            // a load coinciding with an apply becomes the next pending value
            if (load) begin
                pending <= div_val;
                pend    <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    clk_out <= 1'b0;
                    if (en && (next_active != '0)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en && !clk_out) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (hit) begin
                        cnt     <= '0;
                        clk_out <= ~clk_out;
                        tick    <= 1'b1;
                        if (clk_out && (!en || (next_active == '0))) begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (!en) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // en is ignored here; the high phase always completes
                    if (hit) begin
                        cnt     <= '0;
                        clk_out <= 1'b0;
                        tick    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    clk_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - multi-channel divided clock / tick generator
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   en           per-channel run enable
//   div_val      per-channel half-period, channel i at [i*CNT_W +: CNT_W]
//   load         per-channel capture request
//   load_ack     per-channel pulse when a captured value becomes active
//   clk_out      per-channel divided clock
//   tick         per-channel pulse on every clk_out change
//   busy         any channel not IDLE
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       load,
    output logic [NUM_CH-1:0]       load_ack,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic                    busy
);

    logic [NUM_CH-1:0] ch_busy;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en[i]),
            .load     (load[i]),
            .div_val  (div_val[i*CNT_W +: CNT_W]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i]),
            .load_ack (load_ack[i]),
            .busy     (ch_busy[i])
        );
    end

    assign busy = |ch_busy;

endmodule
